// File: rtl/frame_stats_reader_if.sv
// frame_stats_reader_if: burst bus between the statistics reader (master) and the frame buffer (slave).
interface frame_stats_reader_if;
    logic        requestBus;
    logic        busGrant;
    logic        beginTransactionOut;
    logic [31:0] addressDataOut;
    logic        endTransactionOut;
    logic [3:0]  byteEnablesOut;
    logic        readNotWriteOut;
    logic [7:0]  burstSizeOut;
    logic [31:0] addressDataIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic        busErrorIn;
    logic        busyIn;
    modport master (
        output requestBus, beginTransactionOut, addressDataOut, endTransactionOut,
               byteEnablesOut, readNotWriteOut, burstSizeOut,
        input  busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn, busyIn
    );
    modport slave (
        input  requestBus, beginTransactionOut, addressDataOut, endTransactionOut,
               byteEnablesOut, readNotWriteOut, burstSizeOut,
        output busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn, busyIn
    );
endinterface

// File: rtl/frame_stats_reader.sv
// frame_stats_reader: bursts a grayscale frame off the bus and accumulates sum, above-threshold count, min and max.
module frame_stats_reader #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    frame_stats_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQUEST, INIT, READ, ABORT} state_t;
    state_t state, nextState;
    logic [31:0] baseAddress, jobAddress, pixelSum, aboveCount;
    logic [16:0] wordCount, remaining;
    logic [7:0]  threshold, minPixel, maxPixel, wordMin, wordMax;
    logic [4:0]  burstLength, nextBurst;
    logic [9:0]  wordSum;
    logic [2:0]  wordAbove, command;
    logic        busy, done, error, myCi, startCmd, take, burstEnd, unusedBits;

    assign unusedBits = ^{ciValueA[31:3], bus.busyIn};
    assign command = ciValueA[2:0];
    assign myCi = ciN == customInstructionId && ciStart && ciCke;
    assign ciDone = myCi;
    assign startCmd = myCi && command == 3'd3 && !busy;
    assign take = state == READ && bus.dataValidIn;
    assign burstEnd = state == READ && bus.endTransactionIn && !bus.busErrorIn;
    assign nextBurst = remaining > 17'd16 ? 5'd16 : remaining[4:0];
    assign bus.requestBus = state == REQUEST;
    assign ciResult = !myCi ? 32'd0 :
                      command == 3'd4 ? {29'd0, error, done, busy} :
                      command == 3'd5 ? pixelSum :
                      command == 3'd6 ? aboveCount :
                      command == 3'd7 ? {16'd0, minPixel, maxPixel} : 32'd0;

    always_comb begin
        wordSum = 10'd0;
        wordAbove = 3'd0;
        wordMin = minPixel;
        wordMax = maxPixel;
        for (int i = 0; i < 4; i++) begin
            wordSum = wordSum + 10'(bus.addressDataIn[8*i +: 8]);
            wordAbove = wordAbove + 3'(bus.addressDataIn[8*i +: 8] > threshold);
            wordMin = bus.addressDataIn[8*i +: 8] < wordMin ? bus.addressDataIn[8*i +: 8] : wordMin;
            wordMax = bus.addressDataIn[8*i +: 8] > wordMax ? bus.addressDataIn[8*i +: 8] : wordMax;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = startCmd && wordCount != 17'd0 ? REQUEST : IDLE;
            REQUEST: nextState = bus.busErrorIn ? ABORT : bus.busGrant ? INIT : REQUEST;
            INIT:    nextState = bus.busErrorIn ? ABORT : READ;
            READ:    nextState = bus.busErrorIn ? ABORT :
                                 !bus.endTransactionIn ? READ :
                                 remaining != 17'd0 ? REQUEST : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= nextState;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.beginTransactionOut <= 1'b0;
            bus.addressDataOut <= 32'd0;
            bus.byteEnablesOut <= 4'd0;
            bus.readNotWriteOut <= 1'b0;
            bus.burstSizeOut <= 8'd0;
            bus.endTransactionOut <= 1'b0;
            baseAddress <= 32'd0;
            jobAddress <= 32'd0;
            wordCount <= 17'd0;
            remaining <= 17'd0;
            threshold <= 8'd0;
            burstLength <= 5'd0;
            pixelSum <= 32'd0;
            aboveCount <= 32'd0;
            minPixel <= 8'hFF;
            maxPixel <= 8'h00;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            bus.beginTransactionOut <= state == INIT;
            bus.addressDataOut <= state == INIT ? jobAddress : 32'd0;
            bus.byteEnablesOut <= state == INIT ? 4'hF : 4'h0;
            bus.readNotWriteOut <= state == INIT;
            bus.burstSizeOut <= state == INIT ? 8'(nextBurst) - 8'd1 : 8'd0;
            bus.endTransactionOut <= state == ABORT;
            if (myCi && command == 3'd0) baseAddress <= {ciValueB[31:2], 2'b00};
            if (myCi && command == 3'd1) wordCount <= ciValueB[16:0];
            if (myCi && command == 3'd2) threshold <= ciValueB[7:0];
            if (startCmd) begin
                jobAddress <= baseAddress;
                remaining <= wordCount;
                pixelSum <= 32'd0;
                aboveCount <= 32'd0;
                minPixel <= 8'hFF;
                maxPixel <= 8'h00;
                error <= 1'b0;
                done <= wordCount == 17'd0;
                busy <= wordCount != 17'd0;
            end
            if (state == INIT) begin
                remaining <= remaining - 17'(nextBurst);
                burstLength <= nextBurst;
            end
            if (take) begin
                pixelSum <= pixelSum + 32'(wordSum);
                aboveCount <= aboveCount + 32'(wordAbove);
                minPixel <= wordMin;
                maxPixel <= wordMax;
            end
            // a finished burst either advances the address for the next one or completes the job
            if (burstEnd && remaining != 17'd0) jobAddress <= jobAddress + 32'({burstLength, 2'b00});
            if (burstEnd && remaining == 17'd0) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (state == ABORT) begin
                error <= 1'b1;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_stats_reader.sv
// tb_frame_stats_reader: random frames against a word-by-word statistics model with a memory-backed bus slave.
module tb_frame_stats_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ciStart = 1'b0, ciCke = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] ciValueA = 32'd0, ciValueB = 32'd0;
    logic [31:0] ciResult;
    logic        ciDone;
    int checks = 0, failures = 0;
    logic [31:0] mem [256];
    int burstAddr [$];
    int burstSize [$];
    int endPulses = 0, reqCycles = 0, errorBurst = -1, burstIndex = 0;

    frame_stats_reader_if bus ();
    frame_stats_reader #(.customInstructionId(8'd0)) dut (
        .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResult), .ciDone(ciDone), .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ciOp(input logic [2:0] cmd, input logic [31:0] b, output logic [31:0] r);
        @(negedge clock);
        ciN = 8'd0; ciStart = 1'b1; ciCke = 1'b1; ciValueA = {29'd0, cmd}; ciValueB = b;
        #1 r = ciResult;
        @(posedge clock);
        #1 ciStart = 1'b0; ciCke = 1'b0;
    endtask

    function automatic logic [31:0] busIdle();
        return {31'd0, |{bus.beginTransactionOut, bus.addressDataOut, bus.endTransactionOut,
                         bus.byteEnablesOut, bus.readNotWriteOut, bus.burstSizeOut, bus.requestBus}};
    endfunction

    task automatic waitDone(input string tag);
        logic [31:0] r;
        bit ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            ciOp(3'd4, 0, r);
            ok = r[1];
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic model(input int bi, input int cnt, input logic [7:0] thr,
                         output logic [31:0] s, output logic [31:0] a, output logic [7:0] mn, output logic [7:0] mx);
        s = 0; a = 0; mn = 8'hFF; mx = 8'h00;
        for (int w = 0; w < cnt; w++)
            for (int b = 0; b < 4; b++) begin
                logic [31:0] word;
                logic [7:0] p;
                word = mem[(bi + w) & 255];
                p = word[8*b +: 8];
                s = s + 32'(p);
                if (p > thr) a = a + 1;
                if (p < mn) mn = p;
                if (p > mx) mx = p;
            end
    endtask

    task automatic checkBursts(input string tag, input int bi, input int cnt);
        int rem = cnt, addr = 32'h1000 + 4 * bi, k = 0, n;
        check({tag, "_bursts"}, burstAddr.size(), (cnt + 15) / 16);
        while (rem > 0) begin
            n = rem > 16 ? 16 : rem;
            if (k < burstAddr.size()) begin
                check({tag, "_addr"}, burstAddr[k], addr);
                check({tag, "_size"}, burstSize[k], n - 1);
            end
            addr += 4 * n; rem -= n; k++;
        end
    endtask

    task automatic runJob(input string tag, input int bi, input int cnt, input logic [7:0] thr, input bit restartBusy);
        logic [31:0] r, s, a;
        logic [7:0] mn, mx;
        ciOp(3'd0, 32'h1000 + 4 * bi, r);
        ciOp(3'd1, cnt, r);
        ciOp(3'd2, {24'd0, thr}, r);
        burstAddr.delete(); burstSize.delete();
        ciOp(3'd3, 0, r);
        if (restartBusy) begin
            ciOp(3'd1, 5, r);
            ciOp(3'd3, 0, r);
        end
        waitDone(tag);
        model(bi, cnt, thr, s, a, mn, mx);
        ciOp(3'd5, 0, r); check({tag, "_sum"}, r, s);
        ciOp(3'd6, 0, r); check({tag, "_above"}, r, a);
        ciOp(3'd7, 0, r); check({tag, "_minmax"}, r, {16'd0, mn, mx});
        ciOp(3'd4, 0, r); check({tag, "_status"}, r, 32'b010);
        checkBursts(tag, bi, cnt);
        #1 check({tag, "_idle"}, busIdle(), 0);
    endtask

    initial begin
        int a, n;
        bus.busGrant = 0; bus.addressDataIn = 0; bus.dataValidIn = 0;
        bus.endTransactionIn = 0; bus.busErrorIn = 0; bus.busyIn = 0;
        forever begin
            @(posedge clock); #1;
            bus.busGrant = bus.requestBus;
            if (bus.requestBus) reqCycles++;
            if (bus.endTransactionOut) endPulses++;
            if (bus.beginTransactionOut) begin
                bus.busGrant = 0;
                a = bus.addressDataOut;
                n = int'(bus.burstSizeOut) + 1;
                burstAddr.push_back(a);
                burstSize.push_back(n - 1);
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
                    if (burstIndex == errorBurst && i == 1) begin
                        bus.busErrorIn = 1;
                        @(posedge clock); #1 bus.busErrorIn = 0;
                        break;
                    end
                    bus.dataValidIn = 1;
                    bus.addressDataIn = mem[((a - 32'h1000) >> 2) + i & 255];
                    bus.endTransactionIn = i == n - 1;
                    @(posedge clock); #1;
                    bus.dataValidIn = 0; bus.endTransactionIn = 0; bus.addressDataIn = 0;
                end
                burstIndex++;
            end
        end
    end

    initial begin
        logic [31:0] r;
        int reqBefore, endBefore;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 0;
        ciOp(3'd4, 0, r); check("reset_status", r, 0);
        ciOp(3'd7, 0, r); check("reset_minmax", r, 32'hFF00);
        check("reset_bus", busIdle(), 0);
        @(negedge clock);
        ciN = 8'd1; ciStart = 1; ciCke = 1; ciValueA = 32'd7;
        #1 check("foreign_result", ciResult, 0);
        check("foreign_done", {31'd0, ciDone}, 0);
        ciStart = 0; ciCke = 0; ciN = 8'd0;

        mem[0] = 32'h01020304; mem[1] = 32'h80808080; mem[2] = 32'hFF000065;
        runJob("directed", 0, 3, 8'd100, 0);
        ciOp(3'd5, 0, r); check("directed_sum_const", r, 32'h36E);
        ciOp(3'd6, 0, r); check("directed_above_const", r, 6);

        runJob("count40", $urandom_range(3, 150), 40, 8'($urandom), 0);
        runJob("count16", $urandom_range(3, 150), 16, 8'($urandom), 0);
        runJob("count17", $urandom_range(3, 150), 17, 8'($urandom), 0);
        runJob("count1", $urandom_range(3, 150), 1, 8'd255, 0);
        runJob("thr0", $urandom_range(3, 150), 33, 8'd0, 0);
        for (int j = 0; j < 4; j++)
            runJob("random", $urandom_range(3, 150), $urandom_range(1, 60), 8'($urandom), 0);
        runJob("busy_start", $urandom_range(3, 150), 40, 8'($urandom), 1);

        endBefore = endPulses;
        errorBurst = burstIndex + 1;
        ciOp(3'd1, 40, r);
        ciOp(3'd3, 0, r);
        waitDone("abort");
        repeat (2) @(posedge clock);
        #1 reqBefore = reqCycles;
        ciOp(3'd4, 0, r); check("abort_status", r, 32'b110);
        check("abort_end_pulses", endPulses - endBefore, 1);
        repeat (20) @(posedge clock);
        #1 check("abort_no_request", reqCycles - reqBefore, 0);
        errorBurst = -1;

        reqBefore = reqCycles;
        ciOp(3'd1, 0, r);
        ciOp(3'd3, 0, r);
        ciOp(3'd4, 0, r); check("zero_status", r, 32'b010);
        repeat (5) @(posedge clock);
        #1 check("zero_no_request", reqCycles - reqBefore, 0);
        check("zero_bus", busIdle(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
